quad_decoder: RTL and testbench
===============================

# quad_decoder

- Decodes a two-channel quadrature rotary encoder (A/B) into a signed-direction position count, a one-cycle step strobe and a sticky illegal-transition error.
- Sits between the board encoder pins and the up/down position-counting logic: it produces the up/enable events such logic consumes and keeps its own wrapping position register.
- Inputs are asynchronous and are synchronized internally; optional per-channel debounce filtering.

## Interface
- N, 16, width of position count
- DB_CYCLES, 4, consecutive stable synchronized cycles required to accept an input level change (≥1; used only with debounce)
- clk  in  1  system clock
- rst  in  1  reset; rst, synchronous, active-high
- a_in  in  1  encoder channel A, asynchronous
- b_in  in  1  encoder channel B, asynchronous
- clr  in  1  synchronous clear of pos
- err_clr  in  1  clears sticky err
- pos  out  N  position count, unsigned, wraps modulo 2^N
- step  out  1  one-cycle strobe per accepted valid transition
- dir  out  1  direction of last valid transition (1 = up / forward)
- err  out  1  sticky illegal-transition flag

## Operation
- Reset values: pos=0, step=0, dir=1, err=0; sync/filter registers 0; FSM in INIT.
- Synchronizer: 2-FF per channel → a_s, b_s.
- Debounce (per channel): counter increments while a_s ≠ a_f, clears when equal; when the counter reaches DB_CYCLES-1 with inputs still differing, a_f ← a_s and the counter clears. A change must persist DB_CYCLES consecutive cycles.
- FSM states:
  - INIT: settle counter runs DB_CYCLES+2 cycles after rst deasserts, then loads phase ← {a_f,b_f} and enters TRACK. No steps or errors are generated in INIT.
  - TRACK: each cycle compares {a_f,b_f} with the stored phase.
- Forward sequence 00→01→11→10→00 counts up; the reverse sequence counts down. Four counts per encoder detent cycle (x4 decode).
- Valid transition: phase updates; pos ±1 (wraps 2^N-1↔0); step=1 for one cycle; dir updated.
- Equal to phase: no action.
- Both bits change (00↔11, 01↔10): err ← 1, phase resyncs to the new value, pos and dir unchanged, no step.
- clr with a valid step in the same cycle: pos=0 (clr wins); step and dir still reflect the transition.
- err_clr with a new illegal transition in the same cycle: err stays 1 (set wins).
- rst asserted mid-operation: everything returns to reset values next edge; re-enters INIT.

## Timing
- Pin edge to pos/step/dir update: 2 (sync) + DB_CYCLES (filter) + 1 (FSM) cycles; 3 cycles without debounce.
- pos, dir, err and step are all registered and update on the same edge.
- Maximum accepted transition rate: one per DB_CYCLES cycles (one per cycle without debounce).
- clr and err_clr take effect on the next edge.

## Configuration
- QUAD_DEBOUNCE_EN defined: debounce filter instantiated on both channels; latency and settle as stated.
- QUAD_DEBOUNCE_EN undefined: a_f=a_s, b_f=b_s directly; DB_CYCLES ignored; INIT settle is 2 cycles.

## Structure
- Package quad_pkg:
  - phase_t enum {PH00, PH01, PH11, PH10}
  - fsm_t enum {INIT, TRACK}
  - step_decode function: (old, new) → {valid, up, illegal}
- Sub-module quad_debounce: one channel, parameter DB_CYCLES, ports clk/rst/d/q; instantiated twice.

## Test plan
All scenarios use N=16 and DB_CYCLES=4.
- Reset, then hold A=B=0 for 20 cycles → pos=0, step never asserted, err=0, dir=1.
- Four forward steps (00→01→11→10→00), each level held 10 cycles → pos=4, four step pulses, dir=1; first pulse 7 cycles after the pin edge.
- From pos=0, one reverse step 00→10 → pos=0xFFFF, dir=0; then a forward step → pos=0x0000.
- Glitch on A lasting 3 cycles → no step, pos unchanged; the same change held 4 cycles → accepted.
- Jump 00→11 → err=1, pos unchanged; then 11→10 → pos+1, err still 1; pulse err_clr → err=0.
- clr asserted on the same cycle as a step, with pos=5 → pos=0, step=1; rst asserted mid-sequence → pos=0, no step for 6 cycles after release.

Source files
------------

// File: rtl/quad_pkg.sv
// rtl/quad_pkg.sv - shared types and transition decode for the quadrature decoder
package quad_pkg;

    typedef enum logic [1:0] {
        PH00 = 2'b00,
        PH01 = 2'b01,
        PH11 = 2'b11,
        PH10 = 2'b10
    } phase_t;

    typedef enum logic {
        INIT  = 1'b0,
        TRACK = 1'b1
    } fsm_t;

    typedef struct packed {
        logic valid;
        logic up;
        logic illegal;
    } step_t;

    // Position of a phase along the forward Gray sequence 00->01->11->10.
    function automatic logic [1:0] phase_index(input phase_t ph);
        logic [1:0] idx;
        case (ph)
            PH00:    idx = 2'd0;
            PH01:    idx = 2'd1;
            PH11:    idx = 2'd2;
            default: idx = 2'd3;
        endcase
        return idx;
    endfunction

    function automatic step_t step_decode(input phase_t old_ph, input phase_t new_ph);
        step_t      res;
        logic [1:0] diff;
        res  = '0;
        diff = phase_index(new_ph) - phase_index(old_ph);
        case (diff)
            2'd1: begin
                res.valid = 1'b1;
                res.up    = 1'b1;
            end
            2'd3: res.valid   = 1'b1;
            2'd2: res.illegal = 1'b1;
            default: ;
        endcase
        return res;
    endfunction

endpackage

// File: rtl/quad_debounce.sv
// rtl/quad_debounce.sv - single-channel level filter requiring DB_CYCLES stable samples
module quad_debounce #(
    parameter int DB_CYCLES = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);

    localparam int CW = (DB_CYCLES > 1) ? $clog2(DB_CYCLES) : 1;

    logic [CW-1:0] cnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt <= '0;
            q   <= 1'b0;
        end else if (d != q) begin
            if (cnt == CW'(DB_CYCLES - 1)) begin
                q   <= d;
                cnt <= '0;
            end else begin
                cnt <= cnt + CW'(1);
            end
        end else begin
            cnt <= '0;
        end
    end

endmodule

// File: rtl/quad_decoder.sv
// rtl/quad_decoder.sv - x4 quadrature decoder top; QUAD_DEBOUNCE_EN enables input filtering
module quad_decoder
    import quad_pkg::*;
#(
    parameter int N         = 16,
    parameter int DB_CYCLES = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         a_in,
    input  logic         b_in,
    input  logic         clr,
    input  logic         err_clr,
    output logic [N-1:0] pos,
    output logic         step,
    output logic         dir,
    output logic         err
);

    // Sized for the longest settle (debounce build) so both builds share it.
    localparam int SW = $clog2(DB_CYCLES + 3);

    logic a_meta, a_s, b_meta, b_s;
    logic a_f, b_f;

    always_ff @(posedge clk) begin
        if (rst) begin
            a_meta <= 1'b0;
            a_s    <= 1'b0;
            b_meta <= 1'b0;
            b_s    <= 1'b0;
        end else begin
            a_meta <= a_in;
            a_s    <= a_meta;
            b_meta <= b_in;
            b_s    <= b_meta;
        end
    end

`ifdef QUAD_DEBOUNCE_EN
    localparam int SETTLE = DB_CYCLES + 2;

    quad_debounce #(.DB_CYCLES(DB_CYCLES)) u_db_a (
        .clk (clk),
        .rst (rst),
        .d   (a_s),
        .q   (a_f)
    );

    quad_debounce #(.DB_CYCLES(DB_CYCLES)) u_db_b (
        .clk (clk),
        .rst (rst),
        .d   (b_s),
        .q   (b_f)
    );
`else
    localparam int SETTLE = 2;

    assign a_f = a_s;
    assign b_f = b_s;
`endif

    fsm_t          state, state_next;
    phase_t        phase, cur_ph;
    step_t         dec;
    logic [SW-1:0] settle_cnt;
    logic          settle_done;
    logic          load_phase, do_step, set_err;

    assign cur_ph      = phase_t'({a_f, b_f});
    assign settle_done = (settle_cnt == SW'(SETTLE - 1));
    assign dec         = step_decode(phase, cur_ph);

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= INIT;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            INIT:    if (settle_done) state_next = TRACK;
            TRACK:   state_next = TRACK;
            default: state_next = INIT;
        endcase
    end

    always_comb begin
        load_phase = 1'b0;
        do_step    = 1'b0;
        set_err    = 1'b0;
        case (state)
            INIT: load_phase = settle_done;
            TRACK: begin
                do_step    = dec.valid;
                set_err    = dec.illegal;
                load_phase = dec.valid | dec.illegal;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            settle_cnt <= '0;
        end else if (state == INIT) begin
            settle_cnt <= settle_cnt + SW'(1);
        end
    end

    // Illegal jumps resync the phase so tracking resumes from the new position.
    always_ff @(posedge clk) begin
        if (rst) begin
            phase <= PH00;
            pos   <= '0;
            step  <= 1'b0;
            dir   <= 1'b1;
            err   <= 1'b0;
        end else begin
            if (load_phase) phase <= cur_ph;
            step <= do_step;
            if (do_step) dir <= dec.up;
            if (clr) begin
                pos <= '0;
            end else if (do_step) begin
                pos <= dec.up ? pos + N'(1) : pos - N'(1);
            end
            if (set_err) begin
                err <= 1'b1;
            end else if (err_clr) begin
                err <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_quad_decoder.sv
// tb/tb_quad_decoder.sv - directed self-checking bench for quad_decoder
module tb_quad_decoder;

`ifdef QUAD_DEBOUNCE_EN
    localparam int LAT          = 7;
    localparam int GLITCH_STEPS = 0;
`else
    localparam int LAT          = 3;
    localparam int GLITCH_STEPS = 2;
`endif

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        a_in = 1'b0;
    logic        b_in = 1'b0;
    logic        clr = 1'b0;
    logic        err_clr = 1'b0;
    logic [15:0] pos;
    logic        step;
    logic        dir;
    logic        err;

    int checks = 0;
    int errors = 0;
    int steps;
    int first_off;

    quad_decoder #(.N(16), .DB_CYCLES(4)) dut (
        .clk     (clk),
        .rst     (rst),
        .a_in    (a_in),
        .b_in    (b_in),
        .clr     (clr),
        .err_clr (err_clr),
        .pos     (pos),
        .step    (step),
        .dir     (dir),
        .err     (err)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic apply(input logic a, input logic b, input int n);
        a_in = a;
        b_in = b;
        for (int i = 1; i <= n; i++) begin
            tick();
            if (step === 1'b1) begin
                steps++;
                if (first_off < 0) first_off = i;
            end
        end
    endtask

    task automatic clear_counts();
        steps     = 0;
        first_off = -1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        tick();
        tick();
        checks++; if (pos !== 16'h0000) begin errors++; $display("FAIL reset_pos got %h exp 0000", pos); end
        checks++; if (step !== 1'b0) begin errors++; $display("FAIL reset_step got %b exp 0", step); end
        checks++; if (dir !== 1'b1) begin errors++; $display("FAIL reset_dir got %b exp 1", dir); end
        checks++; if (err !== 1'b0) begin errors++; $display("FAIL reset_err got %b exp 0", err); end
        rst = 1'b0;
        clear_counts();
        apply(1'b0, 1'b0, 20);
        checks++; if (steps !== 0) begin errors++; $display("FAIL idle_steps got %0d exp 0", steps); end
        checks++; if (pos !== 16'h0000 || err !== 1'b0 || dir !== 1'b1) begin
            errors++; $display("FAIL idle_state got pos=%h err=%b dir=%b exp pos=0000 err=0 dir=1", pos, err, dir);
        end
    endtask

    task automatic test_forward();
        clear_counts();
        apply(1'b0, 1'b1, 10);
        checks++; if (first_off !== LAT) begin errors++; $display("FAIL fwd_latency got %0d exp %0d", first_off, LAT); end
        apply(1'b1, 1'b1, 10);
        apply(1'b1, 1'b0, 10);
        apply(1'b0, 1'b0, 10);
        checks++; if (pos !== 16'd4) begin errors++; $display("FAIL fwd_pos got %h exp 0004", pos); end
        checks++; if (steps !== 4) begin errors++; $display("FAIL fwd_steps got %0d exp 4", steps); end
        checks++; if (dir !== 1'b1) begin errors++; $display("FAIL fwd_dir got %b exp 1", dir); end
    endtask

    task automatic test_reverse_wrap();
        clr = 1'b1;
        tick();
        clr = 1'b0;
        checks++; if (pos !== 16'h0000) begin errors++; $display("FAIL clr_pos got %h exp 0000", pos); end
        apply(1'b1, 1'b0, 10);
        checks++; if (pos !== 16'hFFFF) begin errors++; $display("FAIL wrap_down_pos got %h exp ffff", pos); end
        checks++; if (dir !== 1'b0) begin errors++; $display("FAIL wrap_down_dir got %b exp 0", dir); end
        apply(1'b0, 1'b0, 10);
        checks++; if (pos !== 16'h0000) begin errors++; $display("FAIL wrap_up_pos got %h exp 0000", pos); end
        checks++; if (dir !== 1'b1) begin errors++; $display("FAIL wrap_up_dir got %b exp 1", dir); end
    endtask

    task automatic test_glitch();
        clear_counts();
        apply(1'b1, 1'b0, 3);
        apply(1'b0, 1'b0, 10);
        checks++; if (steps !== GLITCH_STEPS) begin errors++; $display("FAIL glitch3_steps got %0d exp %0d", steps, GLITCH_STEPS); end
        checks++; if (pos !== 16'h0000) begin errors++; $display("FAIL glitch3_pos got %h exp 0000", pos); end
        clear_counts();
        apply(1'b1, 1'b0, 4);
        apply(1'b0, 1'b0, 12);
        checks++; if (steps !== 2) begin errors++; $display("FAIL glitch4_steps got %0d exp 2", steps); end
        checks++; if (pos !== 16'h0000) begin errors++; $display("FAIL glitch4_pos got %h exp 0000", pos); end
    endtask

    task automatic test_illegal();
        clear_counts();
        apply(1'b1, 1'b1, 10);
        checks++; if (err !== 1'b1) begin errors++; $display("FAIL illegal_err got %b exp 1", err); end
        checks++; if (pos !== 16'h0000 || steps !== 0) begin
            errors++; $display("FAIL illegal_pos got pos=%h steps=%0d exp pos=0000 steps=0", pos, steps);
        end
        apply(1'b1, 1'b0, 10);
        checks++; if (pos !== 16'd1 || err !== 1'b1) begin
            errors++; $display("FAIL resync_step got pos=%h err=%b exp pos=0001 err=1", pos, err);
        end
        err_clr = 1'b1;
        tick();
        err_clr = 1'b0;
        checks++; if (err !== 1'b0) begin errors++; $display("FAIL err_clr got %b exp 0", err); end
        // 10 -> 01 is illegal; err_clr lands on the detection edge
        apply(1'b0, 1'b1, LAT - 1);
        err_clr = 1'b1;
        tick();
        err_clr = 1'b0;
        checks++; if (err !== 1'b1 || step !== 1'b0 || pos !== 16'd1) begin
            errors++; $display("FAIL set_wins got err=%b step=%b pos=%h exp err=1 step=0 pos=0001", err, step, pos);
        end
        apply(1'b0, 1'b1, 5);
        err_clr = 1'b1;
        tick();
        err_clr = 1'b0;
        checks++; if (err !== 1'b0) begin errors++; $display("FAIL err_clr2 got %b exp 0", err); end
    endtask

    task automatic test_clr_step();
        apply(1'b1, 1'b1, 10);
        apply(1'b1, 1'b0, 10);
        apply(1'b0, 1'b0, 10);
        apply(1'b0, 1'b1, 10);
        checks++; if (pos !== 16'd5) begin errors++; $display("FAIL pre_clr_pos got %h exp 0005", pos); end
        apply(1'b1, 1'b1, LAT - 1);
        clr = 1'b1;
        tick();
        clr = 1'b0;
        checks++; if (pos !== 16'h0000 || step !== 1'b1 || dir !== 1'b1) begin
            errors++; $display("FAIL clr_wins got pos=%h step=%b dir=%b exp pos=0000 step=1 dir=1", pos, step, dir);
        end
        apply(1'b1, 1'b1, 3);
        checks++; if (pos !== 16'h0000 || step !== 1'b0) begin
            errors++; $display("FAIL post_clr got pos=%h step=%b exp pos=0000 step=0", pos, step);
        end
    endtask

    task automatic test_rst_mid();
        apply(1'b1, 1'b0, 10);
        checks++; if (pos !== 16'd1) begin errors++; $display("FAIL pre_rst_pos got %h exp 0001", pos); end
        apply(1'b0, 1'b0, 3);
        rst = 1'b1;
        tick();
        checks++; if (pos !== 16'h0000 || step !== 1'b0 || dir !== 1'b1 || err !== 1'b0) begin
            errors++; $display("FAIL mid_rst got pos=%h step=%b dir=%b err=%b exp 0000 0 1 0", pos, step, dir, err);
        end
        rst = 1'b0;
        clear_counts();
        apply(1'b0, 1'b0, 6);
        checks++; if (steps !== 0 || pos !== 16'h0000) begin
            errors++; $display("FAIL post_rst_quiet got steps=%0d pos=%h exp 0 0000", steps, pos);
        end
        clear_counts();
        apply(1'b0, 1'b1, 10);
        checks++; if (steps !== 1 || pos !== 16'd1) begin
            errors++; $display("FAIL post_rst_step got steps=%0d pos=%h exp 1 0001", steps, pos);
        end
    endtask

    initial begin
        clear_counts();
        test_reset();
        test_forward();
        test_reverse_wrap();
        test_glitch();
        test_illegal();
        test_clr_step();
        test_rst_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
